// File: rtl/snake_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : snake_pkg                                                    |
// | Description : Shared cell geometry, figure codes and pixel codes.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package snake_pkg;

   localparam int CELL_SIZE = 5;

   typedef enum logic [3:0] {
      FIG_HEAD_R = 4'd0,
      FIG_HEAD_U = 4'd1,
      FIG_HEAD_L = 4'd2,
      FIG_HEAD_D = 4'd3,
      FIG_BODY   = 4'd4,
      FIG_TAIL_R = 4'd5,
      FIG_TAIL_U = 4'd6,
      FIG_TAIL_L = 4'd7,
      FIG_TAIL_D = 4'd8,
      FIG_CHERRY = 4'd9,
      FIG_EMPTY  = 4'd15
   } figure_t;

   typedef enum logic [1:0] {
      PIX_00 = 2'b00,
      PIX_01 = 2'b01,
      PIX_10 = 2'b10,
      PIX_11 = 2'b11
   } pix_code_t;

   // 5*sub_y + sub_x built from a shift and adds; result spans 0..24.
   function automatic logic [4:0] cell_pixel_index(input logic [2:0] sub_y,
                                                   input logic [2:0] sub_x);
      return {sub_y, 2'b00} + {2'b00, sub_y} + {2'b00, sub_x};
   endfunction

endpackage
`default_nettype wire

// File: rtl/cell_scan_counter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cell_scan_counter                                            |
// | Description : Modulo-5 sub-pixel counter chained to a saturating cell      |
// |               counter; one instance per scan axis.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cell_scan_counter
   import snake_pkg::*;
#(
   parameter int                CELL_W    = 6,
   parameter logic [CELL_W-1:0] LAST_CELL = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clear,
   input  logic              i_step,
   output logic [2:0]        o_sub,
   output logic [CELL_W-1:0] o_cell
);

   localparam logic [2:0] c_SUB_LAST = 3'(CELL_SIZE - 1);

   logic [2:0]        r_sub;
   logic [CELL_W-1:0] r_cell;

   // A wrap out of the last cell is dropped so the address never leaves the grid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sub  <= 3'd0;
         r_cell <= '0;
      end else if (i_clear) begin
         r_sub  <= 3'd0;
         r_cell <= '0;
      end else if (i_step) begin
         if (r_sub == c_SUB_LAST) begin
            if (r_cell != LAST_CELL) begin
               r_sub  <= 3'd0;
               r_cell <= r_cell + 1'b1;
            end
         end else begin
            r_sub <= r_sub + 3'd1;
         end
      end
   end

   assign o_sub  = r_sub;
   assign o_cell = r_cell;

endmodule
`default_nettype wire

// File: rtl/symbol_render_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : symbol_render_sequencer                                      |
// | Description : Walks the VGA beam over the board grid, fetches each cell's  |
// |               5x5 symbol and emits its 12-bit colour, 4-edge latency.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module symbol_render_sequencer
   import snake_pkg::*;
#(
   parameter logic [9:0]  ORIGIN_X  = 10'd120,
   parameter logic [9:0]  ORIGIN_Y  = 10'd40,
   parameter logic [5:0]  GRID_W    = 6'd40,
   parameter logic [5:0]  GRID_H    = 6'd30,
   parameter logic [3:0]  EMPTY_FIG = FIG_EMPTY,
   parameter logic [11:0] COL_BG    = 12'h000,
   parameter logic [11:0] COL_01    = 12'h0F0,
   parameter logic [11:0] COL_10    = 12'hF00,
   parameter logic [11:0] COL_11    = 12'hFFF
) (
   input  logic        clock_25,
   input  logic        resetn,
   input  logic        frame_start,
   input  logic        pixel_valid,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   output logic [5:0]  cell_x,
   output logic [4:0]  cell_y,
   input  logic [3:0]  cell_figure,
   output logic [3:0]  selected_figure,
   input  logic [49:0] selected_symbol,
   output logic [11:0] rgb,
   output logic        rgb_valid
);

   localparam logic [9:0] c_X_LAST  = 10'(int'(ORIGIN_X) + CELL_SIZE * int'(GRID_W) - 1);
   localparam logic [9:0] c_Y_LAST  = 10'(int'(ORIGIN_Y) + CELL_SIZE * int'(GRID_H) - 1);
   localparam logic [5:0] c_CX_LAST = GRID_W - 6'd1;
   localparam logic [4:0] c_CY_LAST = 5'(GRID_H - 6'd1);

   logic       w_in_x;
   logic       w_in_y;
   logic       w_x_clear;
   logic       w_x_step;
   logic       w_y_step;
   logic [2:0] w_sub_x;
   logic [2:0] w_ycnt_sub;
   logic [4:0] w_ycnt_cell;

   assign w_in_x    = (pixel_x >= ORIGIN_X) && (pixel_x <= c_X_LAST);
   assign w_in_y    = (pixel_y >= ORIGIN_Y) && (pixel_y <= c_Y_LAST);
   assign w_x_clear = pixel_valid && (pixel_x == ORIGIN_X);
   assign w_x_step  = pixel_valid && w_in_x;
   assign w_y_step  = pixel_valid && (pixel_x == c_X_LAST) && w_in_y;

   // X counter state after the edge already belongs to the sampled pixel.
   cell_scan_counter #(
      .CELL_W    (6),
      .LAST_CELL (c_CX_LAST)
   ) u_x_counter (
      .clk     (clock_25),
      .rst_n   (resetn),
      .i_clear (w_x_clear),
      .i_step  (w_x_step),
      .o_sub   (w_sub_x),
      .o_cell  (cell_x)
   );

   // Y counter steps on the row's last pixel, so that pixel still uses the old row.
   cell_scan_counter #(
      .CELL_W    (5),
      .LAST_CELL (c_CY_LAST)
   ) u_y_counter (
      .clk     (clock_25),
      .rst_n   (resetn),
      .i_clear (frame_start),
      .i_step  (w_y_step),
      .o_sub   (w_ycnt_sub),
      .o_cell  (w_ycnt_cell)
   );

   logic       r_s1_valid, r_s1_in;
   logic [2:0] r_s1_sub_y;
   logic [4:0] r_cell_y;
   logic       r_s2_valid, r_s2_in;
   logic [2:0] r_s2_sub_x, r_s2_sub_y;
   logic       r_s3_valid, r_s3_in;
   logic [2:0] r_s3_sub_x, r_s3_sub_y;
   logic [3:0] r_s3_fig;

   always_ff @(posedge clock_25 or negedge resetn) begin
      if (!resetn) begin
         r_s1_valid <= 1'b0;
         r_s1_in    <= 1'b0;
         r_s1_sub_y <= 3'd0;
         r_cell_y   <= 5'd0;
         r_s2_valid <= 1'b0;
         r_s2_in    <= 1'b0;
         r_s2_sub_x <= 3'd0;
         r_s2_sub_y <= 3'd0;
         r_s3_valid <= 1'b0;
         r_s3_in    <= 1'b0;
         r_s3_sub_x <= 3'd0;
         r_s3_sub_y <= 3'd0;
         r_s3_fig   <= 4'd0;
      end else begin
         r_s1_valid <= pixel_valid;
         r_s1_in    <= w_in_x && w_in_y;
         if (frame_start) begin
            r_s1_sub_y <= 3'd0;
            r_cell_y   <= 5'd0;
         end else begin
            r_s1_sub_y <= w_ycnt_sub;
            r_cell_y   <= w_ycnt_cell;
         end
         r_s2_valid <= r_s1_valid;
         r_s2_in    <= r_s1_in;
         r_s2_sub_x <= w_sub_x;
         r_s2_sub_y <= r_s1_sub_y;
         r_s3_valid <= r_s2_valid;
         r_s3_in    <= r_s2_in;
         r_s3_sub_x <= r_s2_sub_x;
         r_s3_sub_y <= r_s2_sub_y;
         r_s3_fig   <= cell_figure;
      end
   end

   assign cell_y          = r_cell_y;
   assign selected_figure = cell_figure;

   logic [4:0]  w_k;
   logic [5:0]  w_bit_hi;
   pix_code_t   w_code;
   logic [11:0] w_rgb_next;

   // Pixel k sits MSB-first in the symbol word: bits [49-2k -: 2].
   assign w_k      = cell_pixel_index(r_s3_sub_y, r_s3_sub_x);
   assign w_bit_hi = 6'd49 - {w_k, 1'b0};
   assign w_code   = pix_code_t'(selected_symbol[w_bit_hi -: 2]);

   always_comb begin
      w_rgb_next = COL_BG;
      if (r_s3_valid && r_s3_in && (r_s3_fig != EMPTY_FIG)) begin
         case (w_code)
            PIX_01:  w_rgb_next = COL_01;
            PIX_10:  w_rgb_next = COL_10;
            PIX_11:  w_rgb_next = COL_11;
            default: w_rgb_next = COL_BG;
         endcase
      end
   end

   always_ff @(posedge clock_25 or negedge resetn) begin
      if (!resetn) begin
         rgb       <= COL_BG;
         rgb_valid <= 1'b0;
      end else begin
         rgb       <= w_rgb_next;
         rgb_valid <= r_s3_valid;
      end
   end

endmodule
`default_nettype wire

// File: doc/symbol_render_sequencer.md
Name: symbol_render_sequencer

Overview:
- Sequences the 5x5 symbol ROM (`symbol`) for the VGA scan.
- Tracks which grid cell and which sub-pixel the beam is on, and drives the cell address to the board memory.
- Forwards the returned figure code to the ROM as `selected_figure`, extracts the 2-bit pixel code from `selected_symbol`, and outputs a 12-bit colour.
- Sits between the VGA timing generator and the RGB output register.

Parameters:
- ORIGIN_X, 10'd120, first screen column of the grid
- ORIGIN_Y, 10'd40, first screen row of the grid
- GRID_W, 6'd40, grid width in cells
- GRID_H, 6'd30, grid height in cells
- EMPTY_FIG, 4'd15, figure code meaning empty cell, drawn as background
- COL_BG, 12'h000, colour for code 00 and outside the grid
- COL_01, 12'h0F0, colour for code 01
- COL_10, 12'hF00, colour for code 10
- COL_11, 12'hFFF, colour for code 11

Ports:
- clock_25  in  1  25 MHz pixel clock
- resetn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse coincident with pixel (0,0) of each frame
- pixel_valid  in  1  active-video qualifier for pixel_x/pixel_y
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- cell_x  out  6  board-memory column address
- cell_y  out  5  board-memory row address
- cell_figure  in  4  board-memory data, valid 1 cycle after the address
- selected_figure  out  4  to the symbol ROM; combinational copy of cell_figure
- selected_symbol  in  50  symbol ROM data, valid 1 cycle after selected_figure
- rgb  out  12  pixel colour
- rgb_valid  out  1  rgb corresponds to a pixel_valid pixel

Behaviour:
- Reset (async, resetn=0): all counters 0, cell_x=0, cell_y=0, rgb=COL_BG (12'h000), rgb_valid=0, all pipeline valid bits 0. Deassertion is released synchronously by the top level.
- Stage 0, position tracking, registered on clock_25:
  - in_x = pixel_x in [ORIGIN_X, ORIGIN_X+5*GRID_W-1]; in_y likewise on pixel_y with GRID_H.
  - On pixel_valid && pixel_x==ORIGIN_X: sub_x=0, cell_x=0.
  - Else on pixel_valid && in_x: if sub_x==4 then sub_x=0 and cell_x++, else sub_x++.
  - On frame_start: sub_y=0, cell_y=0. This has priority over the row step.
  - Row step: on pixel_valid && pixel_x==ORIGIN_X+5*GRID_W-1 && in_y: if sub_y==4 then sub_y=0 and cell_y++, else sub_y++.
  - No divider and no multiplier on pixel coordinates.
  - Counters never exceed GRID_W-1 / GRID_H-1: increments are gated by in_x/in_y, and the last cell's wrap is ignored.
- Stage 0 also registers s1_valid=pixel_valid, s1_in=in_x&&in_y, and the sub_x/sub_y offset used for the pixel.
- Stage 1:
  - Board memory returns cell_figure; selected_figure=cell_figure.
  - Delay valid, in-grid flag and offsets by one register stage (s2_*).
  - If s1_in==0, stage 3 forces background regardless of figure.
- Stage 2:
  - ROM returns selected_symbol.
  - Delay s2_* to s3_*, and also delay the figure code to detect EMPTY_FIG.
- Stage 3, registered output:
  - k = 5*sub_y + sub_x (0..24, computed from small constants).
  - code = selected_symbol[49-2k -: 2].
  - rgb = COL_BG if !s3_in or fig==EMPTY_FIG, else the palette entry for code.
  - rgb_valid = s3_valid.
- Latency: exactly 4 clock_25 edges from pixel sample to rgb. The pipeline accepts one pixel per cycle with no stalls. Gaps (pixel_valid=0) propagate as rgb_valid=0 with rgb=COL_BG.
- Boundaries:
  - frame_start coinciding with a row step: frame_start wins.
  - Last pixel of the grid row: cell_x stays GRID_W-1.
  - Reset mid-line: pipeline flushes; output resumes correctly at the next frame_start.
  - Unused figures 10-14 render whatever the ROM returns (all zero → COL_BG).

Decomposition:
- Shared package `snake_pkg`:
  - CELL_SIZE=5
  - figure code localparams: HEAD_R/U/L/D=0-3, BODY=4, TAIL_R/U/L/D=5-8, CHERRY=9, EMPTY=15
  - 2-bit pixel code constants
- One sub-module: `cell_scan_counter`, the modulo-5 sub/cell counter pair. Instantiated twice, for x and y.

Test Plan:
- Reset mid-frame: assert resetn=0 → rgb=12'h000 and rgb_valid=0 immediately; cell_x and cell_y = 0.
- Horizontal tracking: scan row ORIGIN_Y with pixel_x 120..129 → cell_x goes 0 for 5 pixels, then 1; sub_x cycles 0..4; cell_address output is 1 cycle after each pixel.
- Latency: board memory returns figure 4 (body, all 01) for cell (0,0); sample pixel (120,40) at cycle t → rgb=12'h0F0 and rgb_valid=1 at t+4.
- Pixel extraction: figure 0 (head_right), pixel (120,40) → code 01 → 12'h0F0; pixel (121,40) → code 00 → 12'h000.
- Empty/out-of-grid: cell figure 15 → rgb=COL_BG. Pixel (100,40) → rgb=COL_BG with rgb_valid=1. pixel_valid=0 → rgb_valid=0 four cycles later.
- Frame wrap: after the full frame, pulse frame_start → cell_y=0 and sub_y=0 on the next cycle; the last grid row shows cell_y=29 and no overflow.
